// File: rtl/pwm_k_ctrl.sv
// Pointwise multiply-reduce pass over N coefficient pairs: wr_data = (a*b) mod 3329.
// Latency: write 3 cycles after each read; done_o 4 cycles after the last read.
// Backpressure: none; memories answer every read, and start_i while busy is dropped.
module red_k (
    input  logic [23:0] x_i,
    output logic [11:0] r_o
);
    // Barrett with m = floor(2^24/3329); the quotient undershoots by at most 1.
    logic [12:0] q;
    logic [12:0] r;

    assign q   = 13'(({13'd0, x_i} * 37'd5039) >> 24);
    assign r   = x_i[12:0] - 13'(q * 13'd3329);
    assign r_o = 12'((r >= 13'd3329) ? (r - 13'd3329) : r);
endmodule

module pwm_k_ctrl #(
    parameter int N  = 256,
    parameter int AW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_addr_o,
    input  logic [11:0]   a_i,
    input  logic [11:0]   b_i,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [11:0]   wr_data_o,
    output logic          busy_o,
    output logic          done_o
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] k, k_nxt;
    logic [1:0]    drain_cnt, drain_nxt;

    logic          v0, v1, v2;
    logic [AW-1:0] a0, a1, a2;
    logic [23:0]   prod;
    logic [11:0]   red_res, res;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            k         <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            k         <= k_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        drain_nxt = drain_cnt;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = RUN;
                    k_nxt     = '0;
                end
            end
            RUN: begin
                if (k == AW'(N - 1)) begin
                    state_nxt = DRAIN;
                    drain_nxt = '0;
                end else begin
                    k_nxt = k + AW'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt == 2'd2) state_nxt = DONE;
                else                   drain_nxt = drain_cnt + 2'd1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign rd_en_o   = (state == RUN);
    assign rd_addr_o = k;
    assign busy_o    = (state != IDLE);
    assign done_o    = (state == DONE);

    red_k u_red_k (
        .x_i (prod),
        .r_o (red_res)
    );

    // Address and data registers only load with their valid bit so outputs hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v0   <= 1'b0;
            v1   <= 1'b0;
            v2   <= 1'b0;
            a0   <= '0;
            a1   <= '0;
            a2   <= '0;
            prod <= '0;
            res  <= '0;
        end else begin
            v0 <= rd_en_o;
            v1 <= v0;
            v2 <= v1;
            if (rd_en_o) a0 <= k;
            if (v0) begin
                a1   <= a0;
                prod <= {12'd0, a_i} * {12'd0, b_i};
            end
            if (v1) begin
                a2  <= a1;
                res <= red_res;
            end
        end
    end

    assign wr_en_o   = v2;
    assign wr_addr_o = a2;
    assign wr_data_o = res;
endmodule

// File: tb/tb_pwm_k_ctrl.sv
// Directed bench for pwm_k_ctrl: nominal pass timing, modular results, start filtering,
// mid-pass reset abort, and a 4-coefficient build.
module tb_pwm_k_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, start4;
    logic        rd_en, wr_en, busy, done;
    logic [7:0]  rd_addr, wr_addr;
    logic [11:0] a, b, wr_data;
    logic        rd_en4, wr_en4, busy4, done4;
    logic [1:0]  rd_addr4, wr_addr4;
    logic [11:0] a4, b4, wr_data4;

    logic [11:0] amem [256];
    logic [11:0] bmem [256];
    logic [11:0] got  [256];
    logic [11:0] a4mem [4];
    logic [11:0] b4mem [4];

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    pwm_k_ctrl #(.N(256), .AW(8)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .rd_en_o(rd_en), .rd_addr_o(rd_addr), .a_i(a), .b_i(b),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .busy_o(busy), .done_o(done)
    );

    pwm_k_ctrl #(.N(4), .AW(2)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start4),
        .rd_en_o(rd_en4), .rd_addr_o(rd_addr4), .a_i(a4), .b_i(b4),
        .wr_en_o(wr_en4), .wr_addr_o(wr_addr4), .wr_data_o(wr_data4),
        .busy_o(busy4), .done_o(done4)
    );

    // Coefficient memories with one-cycle read latency.
    initial begin
        a = '0; b = '0; a4 = '0; b4 = '0;
    end
    always @(posedge clk) begin
        if (rd_en)  begin a  <= amem[rd_addr];   b  <= bmem[rd_addr];   end
        if (rd_en4) begin a4 <= a4mem[rd_addr4]; b4 <= b4mem[rd_addr4]; end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input int i);
        return (int'(amem[i]) * int'(bmem[i])) % 3329;
    endfunction

    // One N=256 pass; start pulses at 0, s1, s2; optional reset at rst_at.
    task automatic run256(input int s1, input int s2, input int rst_at, input int len);
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            if (c > 0) begin
                if (rst_at >= 0 && c > rst_at) begin
                    chk("abort_rd_en", rd_en, 0);
                    chk("abort_rd_addr", rd_addr, 0);
                    chk("abort_wr_en", wr_en, 0);
                    chk("abort_wr_addr", wr_addr, 0);
                    chk("abort_wr_data", wr_data, 0);
                    chk("abort_busy", busy, 0);
                    chk("abort_done", done, 0);
                end else begin
                    chk("rd_en", rd_en, (c <= 256));
                    chk("wr_en", wr_en, (c >= 4 && c <= 259));
                    chk("busy", busy, (c <= 260));
                    chk("done", done, (c == 260));
                    chk("rd_addr", rd_addr, (c <= 256) ? c - 1 : 255);
                    if (c >= 4 && c <= 259) begin
                        chk("wr_addr", wr_addr, c - 4);
                        chk("wr_data", wr_data, model(c - 4));
                        got[c-4] = wr_data;
                    end else if (c > 259) begin
                        chk("wr_addr_hold", wr_addr, 255);
                        chk("wr_data_hold", wr_data, model(255));
                    end
                end
            end
            start = (c == 0 || c == s1 || c == s2);
            rst   = (c == rst_at);
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        logic [11:0] exp4 [4];
        rst = 1'b1; start = 1'b0; start4 = 1'b0;
        for (int i = 0; i < 256; i++) begin amem[i] = '0; bmem[i] = '0; end

        // Reset wins over a simultaneous start.
        repeat (2) @(negedge clk);
        start = 1'b1; start4 = 1'b1;
        @(negedge clk);
        chk("rst_rd_en", rd_en, 0);     chk("rst_rd_addr", rd_addr, 0);
        chk("rst_wr_en", wr_en, 0);     chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0); chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst4_busy", busy4, 0);     chk("rst4_wr_en", wr_en4, 0);
        rst = 1'b0; start = 1'b0; start4 = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_rd_addr", rd_addr, 0);

        // Hand-computed pairs at addresses 0..4, random elsewhere.
        for (int i = 0; i < 256; i++) begin
            amem[i] = 12'($urandom_range(0, 3328));
            bmem[i] = 12'($urandom_range(0, 3328));
        end
        amem[0] = 12'd3328; bmem[0] = 12'd3328;
        amem[1] = 12'd2;    bmem[1] = 12'd1665;
        amem[2] = 12'd3000; bmem[2] = 12'd3000;
        amem[3] = 12'd1234; bmem[3] = 12'd0;
        amem[4] = 12'd1;    bmem[4] = 12'd2280;
        run256(-1, -1, -1, 266);
        chk("pair0", got[0], 1);
        chk("pair1", got[1], 1);
        chk("pair2", got[2], 1713);
        chk("pair3", got[3], 0);
        chk("pair4", got[4], 2280);

        // Fresh random operands; starts at 50 and 260 must be ignored.
        for (int i = 0; i < 256; i++) begin
            amem[i] = 12'($urandom_range(0, 3328));
            bmem[i] = 12'($urandom_range(0, 3328));
        end
        amem[255] = 12'd3328; bmem[255] = 12'd3328;
        run256(50, 260, -1, 270);

        // Reset mid-pass, then a clean pass.
        run256(-1, -1, 100, 110);
        run256(-1, -1, -1, 266);

        // N=4 build.
        a4mem[0] = 12'd3328; b4mem[0] = 12'd3328; exp4[0] = 12'd1;
        a4mem[1] = 12'd2;    b4mem[1] = 12'd1665; exp4[1] = 12'd1;
        a4mem[2] = 12'd3000; b4mem[2] = 12'd3000; exp4[2] = 12'd1713;
        a4mem[3] = 12'd1;    b4mem[3] = 12'd2280; exp4[3] = 12'd2280;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c > 0) begin
                chk("n4_rd_en", rd_en4, (c <= 4));
                chk("n4_wr_en", wr_en4, (c >= 4 && c <= 7));
                chk("n4_done", done4, (c == 8));
                chk("n4_busy", busy4, (c <= 8));
                if (c >= 4 && c <= 7) begin
                    chk("n4_wr_addr", wr_addr4, c - 4);
                    chk("n4_wr_data", wr_data4, exp4[c-4]);
                end
            end
            start4 = (c == 0);
        end
        start4 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/pwm_k_ctrl.md
PWM_K_CTRL -- requirements
Module: pwm_k_ctrl

Interface
REQ-001 Parameter: N, default 256, coefficients per polynomial (power of two, 2..256).
REQ-002 Parameter: AW, default 8, address width, equal to log2(N).
REQ-003 Port: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_i  input  1  reset, synchronous and active-high.
REQ-005 Port: start_i  input  1  one-cycle request to run a pointwise multiply-reduce pass.
REQ-006 Port: rd_en_o  output  1  operand read strobe to coefficient memories A and B.
REQ-007 Port: rd_addr_o  output  AW  operand read address.
REQ-008 Port: a_i  input  12  coefficient of A, valid the cycle after rd_en_o; value < 3329.
REQ-009 Port: b_i  input  12  coefficient of B, same timing and range as a_i.
REQ-010 Port: wr_en_o  output  1  result write strobe.
REQ-011 Port: wr_addr_o  output  AW  result write address.
REQ-012 Port: wr_data_o  output  12  (a*b) mod 3329.
REQ-013 Port: busy_o  output  1  high while a pass is in progress.
REQ-014 Port: done_o  output  1  one-cycle pulse at pass completion.

Function
REQ-015 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE -> RUN when start_i=1; index counter k cleared to 0.
REQ-017 RUN: rd_en_o=1, rd_addr_o=k every cycle; k increments; RUN -> DRAIN after issuing k=N-1.
REQ-018 DRAIN lasts exactly 3 cycles, then -> DONE; DONE lasts 1 cycle (done_o=1), then -> IDLE.
REQ-019 Pipeline: cycle t read issued; cycle t+1 a_i*b_i registered into a 24-bit product register; cycle t+2 product fed to one red_k instance, 12-bit result registered; cycle t+3 wr_en_o=1, wr_addr_o=k, wr_data_o=result.
REQ-020 Read-to-write latency fixed at 3 cycles; one write per cycle, no bubbles, addresses written in ascending order 0..N-1.
REQ-021 Product is unsigned 12x12 -> 24 bits with no truncation (max 3328^2 = 11,075,584 < 2^24).
REQ-022 Each pipeline stage carries a valid bit and the address; wr_en_o is driven only by the final-stage valid bit.
REQ-023 busy_o=1 in RUN, DRAIN and DONE; 0 in IDLE.
REQ-024 start_i while busy_o=1 is ignored, neither queued nor restarting the pass.
REQ-025 start_i in the DONE cycle is ignored; a new pass needs start_i in IDLE.
REQ-026 Counter k wraps never: it stops at N-1 and is not reused in DRAIN; rd_en_o=0 outside RUN.
REQ-027 rd_addr_o, wr_addr_o and wr_data_o hold their last values when their strobes are low.

Reset
REQ-028 rst_i=1 at a clock edge forces IDLE, k=0 and all pipeline valid bits to 0; it takes priority over start_i.
REQ-029 Output values during and after reset: rd_en_o=0, rd_addr_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, done_o=0.
REQ-030 Reset mid-pass aborts the pass: no further wr_en_o and no done_o for it; the next start_i begins at k=0.

Verification
REQ-031 Timing: start_i at cycle 0, N=256 -> rd_en_o cycles 1..256 (addr 0..255), wr_en_o cycles 4..259 (addr 0..255), done_o cycle 260 only, busy_o cycles 1..260.
REQ-032 Arithmetic: pairs (3328,3328)->1, (2,1665)->1, (3000,3000)->1713, (1234,0)->0, (1,2280)->2280, at the addresses that supplied them.
REQ-033 Random operands < 3329 over a full pass -> every wr_data_o equals (a*b) mod 3329 from a reference model.
REQ-034 start_i pulsed at cycles 0, 50 and 260 -> exactly one pass; done_o only at cycle 260; a second pass after 261 only if start_i is reasserted in IDLE.
REQ-035 rst_i at cycle 100 of a pass -> all outputs 0 from the next cycle; no write or done_o afterwards; a new start_i gives the nominal REQ-031 timing.
REQ-036 N=4 build: start at cycle 0 -> writes cycles 4..7, done_o cycle 8, back to IDLE at cycle 9.
